// File: rtl/down_timer_pkg.sv
// timer_pkg: shared types and constants for the down_timer block.
//   state_t  - FSM states of the timer controller
//   dp_op_t  - datapath operation selected by the controller each cycle
//   DEF_WIDTH - default counter width
package timer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD,    // count and reload register keep their values
        OP_LOAD,    // count <- load_val, reload <- load_val
        OP_DEC,     // count <- count - 1
        OP_RELOAD   // count <- reload register
    } dp_op_t;

endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle of the down_timer.
//   load_val, start, stop, auto_reload : controller -> timer
//   count, busy, done, tc              : timer -> controller
// Modports: master (drives controls, observes status), slave (the timer).
interface down_timer_if #(
    parameter int WIDTH = timer_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output load_val, start, stop, auto_reload,
        input  count, busy, done, tc
    );

    modport slave (
        input  load_val, start, stop, auto_reload,
        output count, busy, done, tc
    );
endinterface

// File: rtl/down_cnt_dp.sv
// down_cnt_dp: count register plus reload register for the down_timer.
//   clk, rst  - clock, asynchronous active-high reset (both registers -> 0)
//   op        - operation to apply on the next rising edge
//   load_val  - value taken by OP_LOAD
//   count     - current count
//   zero      - count == 0
//   nxt_zero  - count will be 0 after the next edge (lets the controller
//               register tc alongside its state)
module down_cnt_dp
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  dp_op_t           op,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             nxt_zero
);

    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] rld_nxt;

    always_comb begin
        count_nxt = count;
        rld_nxt   = rld;
        case (op)
            OP_LOAD: begin
                count_nxt = load_val;
                rld_nxt   = load_val;
            end
            // Controller only issues OP_DEC when count != 0, so no wrap.
            OP_DEC:    count_nxt = count - WIDTH'(1);
            OP_RELOAD: count_nxt = rld;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rld   <= '0;
        end else begin
            count <= count_nxt;
            rld   <= rld_nxt;
        end
    end

    assign zero     = (count == '0);
    assign nxt_zero = (count_nxt == '0);

endmodule

// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer, one-shot or auto-reload.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - down_timer_if.slave: load_val/start/stop/auto_reload in,
//          count/busy/done/tc out
// Edge priority: rst > stop > start > normal countdown. All status outputs
// are flops, so there is no combinational path from inputs to outputs.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    down_timer_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    dp_op_t           op;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             nxt_zero;
    logic             busy_q;
    logic             done_q;
    logic             tc_q;

    down_cnt_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .load_val (bus.load_val),
        .count    (count),
        .zero     (zero),
        .nxt_zero (nxt_zero)
    );

    always_comb begin
        op        = OP_HOLD;
        state_nxt = state;
        if (bus.stop) begin
            state_nxt = IDLE;
        end else if (bus.start) begin
            op        = OP_LOAD;
            state_nxt = RUN;
        end else if (state == RUN) begin
            if (!zero)                op        = OP_DEC;
            else if (bus.auto_reload) op        = OP_RELOAD;
            else                      state_nxt = DONE;
        end
    end

    // Outputs are decoded from next state so they land in the same cycle
    // as the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == RUN);
            done_q <= (state_nxt == DONE);
            tc_q   <= (state_nxt == RUN) && nxt_zero;
        end
    end

    assign bus.count = count;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.tc    = tc_q;

endmodule
